// File: rtl/reg_wb_arbiter.sv
// Two-requester round-robin writeback arbiter with a registered register-file write port.
// Optional bypass compare against the write port when REG_WB_FWD_EN is defined.
module reg_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic              hold_i,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic              RSfwd_o,
  output logic [DATA_W-1:0] RSfwd_data_o,
  output logic              RTfwd_o,
  output logic [DATA_W-1:0] RTfwd_data_o
);

  typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} state_t;

  state_t state, state_nxt;
  logic   grant0, grant1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= LAST1;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (grant0)      state_nxt = LAST0;
    else if (grant1) state_nxt = LAST1;
  end

  // Grants are gated by rst_i so nothing can be accepted while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_i && !hold_i) begin
      if (req0_valid_i && (!req1_valid_i || state == LAST1)) grant0 = 1'b1;
      else if (req1_valid_i)                                 grant1 = 1'b1;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else begin
      RegWrite_o <= 1'b0;
      if (grant0) begin
        RegWrite_o <= |req0_addr_i;
        RDaddr_o   <= req0_addr_i;
        RDdata_o   <= req0_data_i;
      end else if (grant1) begin
        RegWrite_o <= |req1_addr_i;
        RDaddr_o   <= req1_addr_i;
        RDdata_o   <= req1_data_i;
      end
    end
  end

`ifdef REG_WB_FWD_EN
  logic rs_hit, rt_hit;

  assign rs_hit       = RegWrite_o && (RDaddr_o == RSaddr_i) && (|RSaddr_i);
  assign rt_hit       = RegWrite_o && (RDaddr_o == RTaddr_i) && (|RTaddr_i);
  assign RSfwd_o      = rs_hit;
  assign RTfwd_o      = rt_hit;
  assign RSfwd_data_o = rs_hit ? RDdata_o : '0;
  assign RTfwd_data_o = rt_hit ? RDdata_o : '0;
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^{RSaddr_i, RTaddr_i};
  assign RSfwd_o        = 1'b0;
  assign RTfwd_o        = 1'b0;
  assign RSfwd_data_o   = '0;
  assign RTfwd_data_o   = '0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vector table, mid-cycle reset, then random traffic vs a reference model.
module tb_reg_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REG_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req0_valid_i, req1_valid_i, hold_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i, RSaddr_i, RTaddr_i;
  logic [DW-1:0] req0_data_i, req1_data_i;
  logic          req0_ready_o, req1_ready_o, RegWrite_o, RSfwd_o, RTfwd_o;
  logic [AW-1:0] RDaddr_o;
  logic [DW-1:0] RDdata_o, RSfwd_data_o, RTfwd_data_o;

  int checks = 0;
  int errors = 0;

  reg_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
    .hold_i(hold_i), .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
    .RSfwd_o(RSfwd_o), .RSfwd_data_o(RSfwd_data_o), .RTfwd_o(RTfwd_o), .RTfwd_data_o(RTfwd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, " RegWrite"}, DW'(RegWrite_o), DW'(we));
    chk({tag, " RDaddr"}, DW'(RDaddr_o), DW'(a));
    chk({tag, " RDdata"}, RDdata_o, d);
  endtask

  task automatic chk_fwd(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic rs_hit, rt_hit;
    rs_hit = FWD && we && (a == RSaddr_i) && (RSaddr_i != 0);
    rt_hit = FWD && we && (a == RTaddr_i) && (RTaddr_i != 0);
    chk({tag, " RSfwd"}, DW'(RSfwd_o), DW'(rs_hit));
    chk({tag, " RSfwd_data"}, RSfwd_data_o, rs_hit ? d : '0);
    chk({tag, " RTfwd"}, DW'(RTfwd_o), DW'(rt_hit));
    chk({tag, " RTfwd_data"}, RTfwd_data_o, rt_hit ? d : '0);
  endtask

  typedef struct {
    bit            v0, v1, hold;
    bit [AW-1:0]   a0, a1, rs, rt;
    bit [DW-1:0]   d0, d1;
    bit            r0, r1, we;
    bit [AW-1:0]   ea;
    bit [DW-1:0]   ed;
    bit            rsf, rtf;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(bit v0, bit [AW-1:0] a0, bit [DW-1:0] d0, bit v1, bit [AW-1:0] a1,
                              bit [DW-1:0] d1, bit hold, bit [AW-1:0] rs, bit [AW-1:0] rt, bit r0, bit r1,
                              bit we, bit [AW-1:0] ea, bit [DW-1:0] ed, bit rsf, bit rtf);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.hold = hold;
    v.rs = rs; v.rt = rt; v.r0 = r0; v.r1 = r1; v.we = we; v.ea = ea; v.ed = ed;
    v.rsf = rsf; v.rtf = rtf;
    return v;
  endfunction

  // Reference model state
  int          last_grant;
  bit          m_we;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_data;
  bit          pend[2];
  bit [AW-1:0] p_addr[2];
  bit [DW-1:0] p_data[2];
  int          waited[2];

  initial begin
    // Directed sequence starting from reset (req0 wins the first tie).
    vecs[0]  = mk(1, 5, 32'h1234, 0, 0, 0,        0, 0, 0, 1, 0, 1, 5, 32'h1234, 0, 0);
    vecs[1]  = mk(0, 0, 0,        1, 0, 32'hFFFF, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF, 0, 0);
    vecs[2]  = mk(1, 3, 32'hA0,   1, 4, 32'hB0,   0, 0, 0, 1, 0, 1, 3, 32'hA0,   0, 0);
    vecs[3]  = mk(1, 3, 32'hA1,   1, 4, 32'hB0,   0, 0, 0, 0, 1, 1, 4, 32'hB0,   0, 0);
    vecs[4]  = mk(1, 3, 32'hA1,   1, 4, 32'hB1,   0, 0, 0, 1, 0, 1, 3, 32'hA1,   0, 0);
    vecs[5]  = mk(1, 3, 32'hA2,   1, 4, 32'hB1,   0, 0, 0, 0, 1, 1, 4, 32'hB1,   0, 0);
    vecs[6]  = mk(1, 3, 32'hA2,   1, 4, 32'hB2,   1, 0, 0, 0, 0, 0, 4, 32'hB1,   0, 0);
    vecs[7]  = mk(1, 3, 32'hA2,   1, 4, 32'hB2,   1, 0, 0, 0, 0, 0, 4, 32'hB1,   0, 0);
    vecs[8]  = mk(1, 3, 32'hA2,   1, 4, 32'hB2,   1, 0, 0, 0, 0, 0, 4, 32'hB1,   0, 0);
    vecs[9]  = mk(1, 3, 32'hA2,   1, 4, 32'hB2,   0, 0, 0, 1, 0, 1, 3, 32'hA2,   0, 0);
    vecs[10] = mk(0, 0, 0,        0, 4, 32'hB2,   0, 0, 0, 0, 0, 0, 3, 32'hA2,   0, 0);
    vecs[11] = mk(1, 7, 32'h55,   0, 0, 0,        0, 7, 8, 1, 0, 1, 7, 32'h55,   FWD, 0);
    vecs[12] = mk(0, 0, 0,        0, 0, 0,        0, 7, 8, 0, 0, 0, 7, 32'h55,   0, 0);

    rst_i = 1'b0; hold_i = 1'b0;
    req0_valid_i = 1'b1; req0_addr_i = 5'd9; req0_data_i = 32'h99;
    req1_valid_i = 1'b1; req1_addr_i = 5'd2; req1_data_i = 32'h22;
    RSaddr_i = '0; RTaddr_i = '0;
    #3;
    chk_regs("reset", 0, 0, 0);
    chk("reset ready0", DW'(req0_ready_o), 0);
    chk("reset ready1", DW'(req1_ready_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      req0_valid_i = vecs[i].v0; req0_addr_i = vecs[i].a0; req0_data_i = vecs[i].d0;
      req1_valid_i = vecs[i].v1; req1_addr_i = vecs[i].a1; req1_data_i = vecs[i].d1;
      hold_i = vecs[i].hold; RSaddr_i = vecs[i].rs; RTaddr_i = vecs[i].rt;
      #1;
      chk({tag, " ready0"}, DW'(req0_ready_o), DW'(vecs[i].r0));
      chk({tag, " ready1"}, DW'(req1_ready_o), DW'(vecs[i].r1));
      @(posedge clk_i); #1;
      chk_regs(tag, vecs[i].we, vecs[i].ea, vecs[i].ed);
      chk({tag, " RSfwd"}, DW'(RSfwd_o), DW'(vecs[i].rsf));
      chk({tag, " RSfwd_data"}, RSfwd_data_o, vecs[i].rsf ? vecs[i].ed : '0);
      chk({tag, " RTfwd"}, DW'(RTfwd_o), DW'(vecs[i].rtf));
      @(negedge clk_i);
    end

    // Grant, then pull reset low mid-cycle: outputs must clear with no clock edge.
    req0_valid_i = 1'b1; req0_addr_i = 5'd9; req0_data_i = 32'h77;
    req1_valid_i = 1'b0; hold_i = 1'b0;
    @(posedge clk_i); #1;
    chk_regs("pre-rst grant", 1, 9, 32'h77);
    #2 rst_i = 1'b0;
    #1;
    chk_regs("async rst", 0, 0, 0);
    chk("async rst ready0", DW'(req0_ready_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    req0_valid_i = 1'b0;

    // Random traffic against the model; FSM is back at "req1 granted last".
    last_grant = 1; m_we = 0; m_addr = 0; m_data = 0;
    pend[0] = 0; pend[1] = 0; waited[0] = 0; waited[1] = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom % 3 != 0)) begin
          pend[r] = 1; p_addr[r] = AW'($urandom_range(0, 7)); p_data[r] = $urandom;
        end
      end
      hold_i = ($urandom % 5 == 0);
      RSaddr_i = AW'($urandom_range(0, 7)); RTaddr_i = AW'($urandom_range(0, 7));
      req0_valid_i = pend[0]; req0_addr_i = p_addr[0]; req0_data_i = p_data[0];
      req1_valid_i = pend[1]; req1_addr_i = p_addr[1]; req1_data_i = p_data[1];
      g = -1;
      if (!hold_i) begin
        if (pend[0] && pend[1]) g = 1 - last_grant;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
      end
      #1;
      chk("rand ready0", DW'(req0_ready_o), DW'(g == 0));
      chk("rand ready1", DW'(req1_ready_o), DW'(g == 1));
      @(posedge clk_i);
      if (g >= 0) begin
        m_we = (p_addr[g] != 0); m_addr = p_addr[g]; m_data = p_data[g];
        last_grant = g; pend[g] = 0; waited[g] = 0;
        if (pend[1-g]) waited[1-g]++;
        checks++;
        if (waited[1-g] > 1) begin
          errors++;
          $display("FAIL starvation: requester %0d waited %0d grants, expected at most 1", 1-g, waited[1-g]);
        end
      end else begin
        m_we = 0;
      end
      #1;
      chk_regs("rand", m_we, m_addr, m_data);
      chk_fwd("rand", m_we, m_addr, m_data);
      @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0_valid_i / req1_valid_i  input  1  writeback request valid.
REQ-006 The block SHALL have ports req0_addr_i / req1_addr_i  input  ADDR_W  destination register.
REQ-007 The block SHALL have ports req0_data_i / req1_data_i  input  DATA_W  write data.
REQ-008 The block SHALL have ports req0_ready_o / req1_ready_o  output  1  request accepted this cycle (combinational).
REQ-009 The block SHALL have port hold_i  input  1  freeze arbitration; no request accepted.
REQ-010 The block SHALL have ports RegWrite_o  output  1, RDaddr_o  output  ADDR_W, RDdata_o  output  DATA_W  registered write port to the register file.
REQ-011 The block SHALL have ports RSaddr_i / RTaddr_i  input  ADDR_W  read addresses for bypass compare.
REQ-012 The block SHALL have ports RSfwd_o / RTfwd_o  output  1 and RSfwd_data_o / RTfwd_data_o  output  DATA_W  bypass hit and data.

Function
REQ-013 A handshake SHALL complete on a cycle where reqN_valid_i and reqN_ready_o are both 1; request fields SHALL be held stable by the requester until then.
REQ-014 With hold_i=1, both ready outputs SHALL be 0 and the arbitration state SHALL not change.
REQ-015 With hold_i=0 and exactly one valid, that requester SHALL get ready=1.
REQ-016 With hold_i=0 and both valid, ready SHALL go to the requester not granted last (round-robin); the loser SHALL see ready=0.
REQ-017 Arbitration state SHALL be a two-state FSM, LAST0/LAST1, entering LAST0 on a req0 grant and LAST1 on a req1 grant, otherwise holding.
REQ-018 On a handshake, RDaddr_o/RDdata_o SHALL load the granted request at the next edge (latency 1 cycle).
REQ-019 RegWrite_o SHALL be 1 for exactly that one cycle unless the granted address is 0.
REQ-020 A granted write to address 0 SHALL complete normally (ready=1) with RegWrite_o=0.
REQ-021 RegWrite_o SHALL be 0 in any cycle following a cycle with no handshake; RDaddr_o/RDdata_o SHALL then hold their previous values.
REQ-022 Both requesters targeting the same address SHALL be serialized by REQ-016; the later grant's data SHALL be written last.
REQ-023 No requester SHALL wait more than one grant while continuously valid and hold_i=0.

Reset
REQ-024 rst_i=0 SHALL immediately force RegWrite_o=0, RDaddr_o=0, RDdata_o=0, FSM=LAST1 (req0 wins first tie), regardless of clk_i.
REQ-025 Ready outputs SHALL be 0 while rst_i=0; a handshake in progress at reset SHALL be discarded.
REQ-026 Operation SHALL resume on the first rising clk_i edge after rst_i returns to 1.

Configuration
REQ-027 Macro REG_WB_FWD_EN SHALL control the bypass logic.
REQ-028 With REG_WB_FWD_EN defined, RSfwd_o SHALL be 1 when RegWrite_o=1, RDaddr_o=RSaddr_i and RSaddr_i!=0, with RSfwd_data_o=RDdata_o; otherwise RSfwd_o=0 and RSfwd_data_o=0 (same for RT).
REQ-029 Without REG_WB_FWD_EN, the bypass ports SHALL remain present and be driven constant 0.

Verification
REQ-030 Reset then req0 only (addr 5, data 0x1234) -> ready0=1 same cycle; next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=0x1234.
REQ-031 Both valid for 4 cycles (req0 addr 3 data 0xA, req1 addr 4 data 0xB), each re-presenting new data after acceptance -> grants alternate 0,1,0,1; RegWrite_o high 4 consecutive cycles.
REQ-032 req1 valid addr 0 data 0xFFFF -> ready1=1; next cycle RegWrite_o=0.
REQ-033 hold_i=1 for 3 cycles with both valid -> no ready, RegWrite_o=0; after release req0 granted first if FSM in LAST1.
REQ-034 rst_i pulled low mid-clock one cycle after a grant -> RegWrite_o, RDaddr_o, RDdata_o=0 without a clock edge.
REQ-035 With REG_WB_FWD_EN, write addr 7 data 0x55 while RSaddr_i=7, RTaddr_i=8 -> RSfwd_o=1, RSfwd_data_o=0x55, RTfwd_o=0; without macro both 0.
